tape_out_decoder: RTL and testbench
===================================

// Module: tape_out_decoder
// PURPOSE
//  Capture side of the cassette path: decodes the Oric fast-format bitstream driven on K7_TAPEOUT into bytes.
//  Measures the period between rising edges, classifies each period as bit 1, bit 0 or gap, and frames start/data/parity/stop.
//  Pushes the decoded bytes into a small FIFO that the HPS upload logic drains.
//  Sits beside the cassette loader in emu, in the clk_sys domain. The loader handles TAP to RAM; this block handles the CPU save path back to a file.
// PARAMETERS
//  CLK_HZ      24000000  clk_sys frequency; sets the 1 us tick prescaler (CLK_HZ/1e6, integer)
//  FIFO_AW     4         FIFO address width; depth = 2**FIFO_AW bytes
//  T_MIN_US    150       periods shorter than this are glitches and are ignored
//  T_SPLIT_US  312       period < T_SPLIT_US is bit 1; otherwise bit 0
//  T_GAP_US    600       period >= T_GAP_US, or no edge for T_GAP_US, is a gap
// PORTS
//  clk_sys     in   1   system clock
//  reset_n     in   1   asynchronous reset, active low
//  enable      in   1   decode enable; 0 holds the framer in IDLE (FIFO untouched)
//  tape_out    in   1   raw K7_TAPEOUT level (asynchronous to logic; synchronised inside)
//  clear       in   1   sync pulse: empties the FIFO, zeroes byte_cnt, clears sticky flags
//  fifo_rd     in   1   pop strobe; ignored when fifo_empty
//  fifo_dout   out  8   head-of-FIFO byte; valid while !fifo_empty
//  fifo_empty  out  1   FIFO holds 0 bytes
//  fifo_count  out  FIFO_AW+1  bytes held
//  byte_cnt    out  16  bytes framed since clear; wraps at 65535 -> 0
//  parity_err  out  1   sticky: a byte failed the odd-parity check
//  overflow    out  1   sticky: a byte was dropped because the FIFO was full
//  active      out  1   high while the framer is outside IDLE (LED drive)
// BEHAVIOUR
//  - Reset: all outputs 0, except fifo_empty=1. FIFO pointers, prescaler, period counter and framer go to IDLE.
//  - Input: 2-flop synchroniser, then rising-edge detect. Edge-to-classification latency is 3 clk_sys cycles.
//  - Period counter:
//    - counts 1 us ticks and saturates at T_GAP_US.
//    - On an edge, classifies the count, then restarts at 0.
//    - Saturation with no edge raises a gap event once.
//  - Classification of period p:
//    - p < T_MIN_US: glitch. Counter is NOT restarted; the edge is ignored.
//    - p < T_SPLIT_US: sym=1. p < T_GAP_US: sym=0. Otherwise: gap.
//  - Framer FSM:
//    - IDLE: sym=0 -> DATA with bit index 0. sym=1 and gap are ignored (leader/sync tone).
//    - DATA: shift sym in LSB-first. After 8 symbols -> PAR.
//    - PAR: capture the parity bit -> STOP.
//    - STOP: sym=1 -> commit byte, then IDLE. sym=0 -> discard byte, then IDLE (framing error, no flag).
//    - gap in any non-IDLE state: discard the partial byte, then IDLE.
//  - Commit:
//    - Parity is odd: XOR(data, par) must be 1; otherwise set parity_err. The byte is still pushed.
//    - byte_cnt increments on every commit, including when the byte is dropped.
//    - FIFO full: drop the byte and set overflow.
//  - FIFO: push and pop in the same cycle are both honoured and fifo_count is unchanged. fifo_dout updates the cycle after a pop.
//  - enable=0: the framer is forced to IDLE the same cycle. The partial byte is discarded.
//  - clear takes priority over a same-cycle commit; the committed byte is lost.
//  - Reset asserted mid-byte: everything is abandoned immediately.
// TESTING
//  - Reset, then idle: fifo_empty=1, fifo_count=0, active=0, byte_cnt=0.
//  - Leader of 20 periods of 208 us, then byte 0x5A framed as start0, bits LSB-first, par=1, stop1.
//    Required: fifo_dout=0x5A, fifo_count=1, byte_cnt=1, parity_err=0.
//  - Byte 0x01 sent with par=1 (wrong):
//    Required: 0x01 is queued and parity_err=1 stays set until clear.
//  - Start + 4 data bits, then the line held low 700 us:
//    Required: no push, active falls to 0. The next full byte 0xC3 decodes correctly.
//  - 100 us glitch pulses between 416 us cycles: ignored, decoded byte unchanged.
//  - 17 bytes with no pops (FIFO_AW=4):
//    Required: count=16, overflow=1, byte_cnt=17. The pop order returns bytes 1..16. A pop with a simultaneous push keeps the count.

Source files
------------

// File: rtl/tape_out_decoder.sv
// rtl/tape_out_decoder.sv - Oric fast-format tape_out bitstream to byte FIFO decoder.
// Period-classifies rising edges into 1/0/gap symbols, frames start/8 data/parity/stop bytes.
module tape_out_decoder #(
   parameter int CLK_HZ     = 24000000,
   parameter int FIFO_AW    = 4,
   parameter int T_MIN_US   = 150,
   parameter int T_SPLIT_US = 312,
   parameter int T_GAP_US   = 600
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   input  logic               enable,
   input  logic               tape_out,
   input  logic               clear,
   input  logic               fifo_rd,
   output logic [7:0]         fifo_dout,
   output logic               fifo_empty,
   output logic [FIFO_AW:0]   fifo_count,
   output logic [15:0]        byte_cnt,
   output logic               parity_err,
   output logic               overflow,
   output logic               active
);

   localparam int DIV   = CLK_HZ / 1000000;
   localparam int PW    = $clog2(DIV + 1);
   localparam int CW    = $clog2(T_GAP_US + 1);
   localparam int DEPTH = 1 << FIFO_AW;

   typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

   logic [2:0]         sync;
   logic [PW-1:0]      pre;
   logic [CW-1:0]      per;
   logic               rise, tick, accept;
   logic               sym_vld, sym_val, gap_vld;
   state_t             state, state_n;
   logic [7:0]         shreg, shreg_n;
   logic [2:0]         idx, idx_n;
   logic               par_bit, par_n, commit, parity_ok;
   logic [FIFO_AW:0]   wr_ptr, rd_ptr;
   logic [7:0]         mem [DEPTH];
   logic               pop, push, full;

   // sync[1:0] is the synchroniser, sync[2] the previous synchronised level
   assign rise   = sync[1] & ~sync[2];
   assign tick   = (pre == PW'(DIV - 1));
   assign accept = rise && (per >= CW'(T_MIN_US));

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sync    <= '0;
         pre     <= '0;
         per     <= '0;
         sym_vld <= 1'b0;
         sym_val <= 1'b0;
         gap_vld <= 1'b0;
      end else begin
         sync    <= {sync[1:0], tape_out};
         sym_vld <= accept && (per < CW'(T_GAP_US));
         sym_val <= per < CW'(T_SPLIT_US);
         // edge on a saturated count, or the count just reaching saturation
         gap_vld <= (accept && (per >= CW'(T_GAP_US))) ||
                    (!accept && tick && (per == CW'(T_GAP_US - 1)));
         if (accept) begin
            pre <= '0;
            per <= '0;
         end else begin
            pre <= tick ? '0 : pre + PW'(1);
            if (tick && (per != CW'(T_GAP_US)))
               per <= per + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         shreg   <= '0;
         idx     <= '0;
         par_bit <= 1'b0;
      end else begin
         state   <= state_n;
         shreg   <= shreg_n;
         idx     <= idx_n;
         par_bit <= par_n;
      end
   end

   always_comb begin
      state_n = state;
      shreg_n = shreg;
      idx_n   = idx;
      par_n   = par_bit;
      commit  = 1'b0;
      if (!enable || gap_vld) begin
         state_n = IDLE;
      end else if (sym_vld) begin
         case (state)
            IDLE: if (!sym_val) begin
               state_n = DATA;
               idx_n   = '0;
            end
            DATA: begin
               shreg_n = {sym_val, shreg[7:1]};
               idx_n   = idx + 3'd1;
               if (idx == 3'd7)
                  state_n = PAR;
            end
            PAR: begin
               par_n   = sym_val;
               state_n = STOP;
            end
            STOP: begin
               commit  = sym_val;
               state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   assign active     = (state != IDLE);
   assign parity_ok  = ^{shreg, par_bit};
   assign fifo_count = wr_ptr - rd_ptr;
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign full       = (fifo_count == (FIFO_AW + 1)'(DEPTH));
   assign pop        = fifo_rd && !fifo_empty;
   // a same-cycle pop frees the slot, so a full FIFO still accepts the byte
   assign push       = commit && (!full || pop);
   assign fifo_dout  = fifo_empty ? 8'h00 : mem[rd_ptr[FIFO_AW-1:0]];

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         byte_cnt   <= '0;
         parity_err <= 1'b0;
         overflow   <= 1'b0;
      end else if (clear) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         byte_cnt   <= '0;
         parity_err <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (commit) begin
            byte_cnt <= byte_cnt + 16'd1;
            if (!parity_ok)
               parity_err <= 1'b1;
            if (!push)
               overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (push && !clear)
         mem[wr_ptr[FIFO_AW-1:0]] <= shreg;
   end

endmodule

// File: tb/tb_tape_out_decoder.sv
// tb/tb_tape_out_decoder.sv - directed bench for tape_out_decoder with a symbol-level reference model.
module tb_tape_out_decoder;

   localparam int DIV    = 4;
   localparam int TMIN   = 15;
   localparam int TSPLIT = 31;
   localparam int TGAP   = 60;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b1;
   logic        tape_out = 1'b0;
   logic        clear = 1'b0;
   logic        fifo_rd = 1'b0;
   logic [7:0]  fifo_dout;
   logic        fifo_empty;
   logic [4:0]  fifo_count;
   logic [15:0] byte_cnt;
   logic        parity_err, overflow, active;

   tape_out_decoder #(
      .CLK_HZ(DIV * 1000000), .FIFO_AW(4),
      .T_MIN_US(TMIN), .T_SPLIT_US(TSPLIT), .T_GAP_US(TGAP)
   ) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .enable(enable), .tape_out(tape_out),
      .clear(clear), .fifo_rd(fifo_rd), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
      .fifo_count(fifo_count), .byte_cnt(byte_cnt), .parity_err(parity_err),
      .overflow(overflow), .active(active)
   );

   always #5 clk_sys = ~clk_sys;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, want);
      end
   endtask

   // reference model: edges in cycles -> symbols -> frames -> byte queue
   int   cyc = 0, last_k = 0, tmo_due = -1, el, kind;
   bit   prev_tape = 0, in_frame = 0, got, commit_v, model_run = 0;
   int   ev_due[$];
   int   ev_kind[$];
   int   bits[$];
   logic [7:0] mq[$];
   logic [7:0] d;
   logic pb;
   int   m_cnt = 0;
   bit   m_perr = 0, m_ovf = 0;

   initial forever begin
      @(posedge clk_sys);
      cyc++;
      if (!reset_n) begin
         last_k = cyc; tmo_due = -1; in_frame = 0; prev_tape = tape_out;
         ev_due.delete(); ev_kind.delete(); bits.delete(); mq.delete();
         m_cnt = 0; m_perr = 0; m_ovf = 0;
      end else begin
         if (tape_out && !prev_tape && ((cyc - last_k) / DIV >= TMIN)) begin
            el = (cyc - last_k) / DIV;
            last_k = cyc;
            ev_due.push_back(cyc + 3);
            ev_kind.push_back(el >= TGAP ? 2 : (el < TSPLIT ? 1 : 0));
            tmo_due = cyc + 2 + TGAP * DIV + 1;
         end
         prev_tape = tape_out;
         got = 0;
         commit_v = 0;
         if (ev_due.size() > 0 && ev_due[0] == cyc) begin
            kind = ev_kind.pop_front();
            void'(ev_due.pop_front());
            got = 1;
         end else if (cyc == tmo_due) begin
            kind = 2;
            got = 1;
         end
         if (got) begin
            if (kind == 2) in_frame = 0;
            else if (!in_frame) begin
               if (kind == 0) begin in_frame = 1; bits.delete(); end
            end else begin
               bits.push_back(kind);
               if (bits.size() == 10) begin
                  in_frame = 0;
                  if (bits[9] == 1) begin
                     commit_v = 1;
                     for (int i = 0; i < 8; i++) d[i] = bits[i][0];
                     pb = bits[8][0];
                  end
               end
            end
         end
         if (clear) begin
            mq.delete(); m_cnt = 0; m_perr = 0; m_ovf = 0;
         end else begin
            if (fifo_rd && mq.size() > 0) void'(mq.pop_front());
            if (commit_v) begin
               m_cnt = (m_cnt + 1) % 65536;
               if ((^d ^ pb) == 1'b0) m_perr = 1;
               if (mq.size() < 16) mq.push_back(d);
               else m_ovf = 1;
            end
         end
      end
   end

   logic [7:0] w_dout, a_dout;
   initial forever begin
      @(negedge clk_sys);
      if (model_run) begin
         w_dout = (mq.size() > 0) ? mq[0] : 8'h00;
         a_dout = (mq.size() > 0) ? fifo_dout : 8'h00;
         chk("cycle", {7'd0, fifo_count, fifo_empty, byte_cnt, parity_err, overflow, active, a_dout},
                      {7'd0, 5'(mq.size()), mq.size() == 0, 16'(m_cnt), m_perr, m_ovf, in_frame, w_dout});
      end
   end

   task automatic hold(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   // one symbol period ending in a rising edge; tape is high on entry
   task automatic sym(input bit b, input bit gl);
      int p;
      p = b ? 21 * DIV : 42 * DIV;
      if (gl) begin
         hold(16); tape_out = 1'b0; hold(24); tape_out = 1'b1;
         hold(20); tape_out = 1'b0; hold(p - 60);
      end else begin
         hold(p / 2); tape_out = 1'b0; hold(p - p / 2);
      end
      tape_out = 1'b1;
   endtask

   task automatic leader(input int n);
      for (int i = 0; i < n; i++) sym(1'b1, 1'b0);
   endtask

   task automatic send_byte(input logic [7:0] db, input bit par, input bit gl, input bit pop_at_commit);
      sym(1'b0, gl);
      for (int i = 0; i < 8; i++) sym(db[i], gl);
      sym(par, gl);
      sym(1'b1, gl);
      if (pop_at_commit) begin
         hold(3); fifo_rd = 1'b1; hold(1); fifo_rd = 1'b0; hold(2);
      end else begin
         hold(5);
      end
   endtask

   task automatic pop_chk(input string nm, input logic [7:0] want);
      chk(nm, {32'd0, fifo_dout}, {32'd0, want});
      fifo_rd = 1'b1; hold(1); fifo_rd = 1'b0; hold(1);
   endtask

   task automatic do_clear();
      clear = 1'b1; hold(1); clear = 1'b0; hold(1);
   endtask

   initial begin
      logic [7:0] v;
      hold(3);
      chk("rst_empty", {39'd0, fifo_empty}, 40'd1);
      chk("rst_count", {35'd0, fifo_count}, 40'd0);
      chk("rst_active", {39'd0, active}, 40'd0);
      chk("rst_dout", {32'd0, fifo_dout}, 40'd0);
      reset_n = 1'b1;
      model_run = 1'b1;
      hold(10);
      chk("idle_bytecnt", {24'd0, byte_cnt}, 40'd0);
      chk("idle_active", {39'd0, active}, 40'd0);

      tape_out = 1'b1;
      leader(20);
      send_byte(8'h5A, 1'b1, 1'b0, 1'b0);
      chk("b5a_dout", {32'd0, fifo_dout}, 40'h5A);
      chk("b5a_count", {35'd0, fifo_count}, 40'd1);
      chk("b5a_bytecnt", {24'd0, byte_cnt}, 40'd1);
      chk("b5a_perr", {39'd0, parity_err}, 40'd0);

      leader(2);
      send_byte(8'h01, 1'b1, 1'b0, 1'b0);
      chk("b01_perr", {39'd0, parity_err}, 40'd1);
      chk("b01_count", {35'd0, fifo_count}, 40'd2);
      pop_chk("pop_5a", 8'h5A);
      pop_chk("pop_01", 8'h01);
      chk("perr_sticky", {39'd0, parity_err}, 40'd1);
      do_clear();
      chk("clr_perr", {39'd0, parity_err}, 40'd0);
      chk("clr_bytecnt", {24'd0, byte_cnt}, 40'd0);

      leader(2);
      sym(1'b0, 1'b0);
      sym(1'b1, 1'b0); sym(1'b0, 1'b0); sym(1'b1, 1'b0); sym(1'b1, 1'b0);
      hold(4);
      chk("part_active", {39'd0, active}, 40'd1);
      hold(40); tape_out = 1'b0; hold(320);
      chk("gap_active", {39'd0, active}, 40'd0);
      chk("gap_count", {35'd0, fifo_count}, 40'd0);
      tape_out = 1'b1;
      leader(2);
      send_byte(8'hC3, 1'b1, 1'b0, 1'b0);
      chk("bc3_dout", {32'd0, fifo_dout}, 40'hC3);
      chk("bc3_bytecnt", {24'd0, byte_cnt}, 40'd1);

      leader(2);
      send_byte(8'h96, 1'b1, 1'b1, 1'b0);
      chk("glitch_count", {35'd0, fifo_count}, 40'd2);
      pop_chk("pop_c3", 8'hC3);
      pop_chk("pop_96", 8'h96);
      do_clear();

      leader(2);
      for (int i = 1; i <= 17; i++) begin
         v = i[7:0];
         send_byte(v, ~^v, 1'b0, 1'b0);
      end
      chk("ovf_count", {35'd0, fifo_count}, 40'd16);
      chk("ovf_flag", {39'd0, overflow}, 40'd1);
      chk("ovf_bytecnt", {24'd0, byte_cnt}, 40'd17);
      for (int i = 1; i <= 8; i++) pop_chk("pop_order", 8'(i));
      leader(2);
      send_byte(8'h77, 1'b1, 1'b0, 1'b1);
      chk("pushpop_count", {35'd0, fifo_count}, 40'd8);
      for (int i = 10; i <= 16; i++) pop_chk("pop_order2", 8'(i));
      pop_chk("pop_77", 8'h77);
      chk("final_empty", {39'd0, fifo_empty}, 40'd1);

      hold(10);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
